div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Serial radix-2 restoring divider: the DIV execution pipe directly downstream of the dispatcher.
- Consumes the dispatcher's DIV issue bundle and computes RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
- Presents one write-back beat to WB.
- Pulses div_done so the dispatcher releases its DIV stall.

Parameters:
- XLEN, 32, operand/result width.
- ENABLE_FAST_SPECIAL, 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  abort in-flight op (driven by the same flush_div the dispatcher uses)
- in_valid  in  1  dispatcher_div_inf.ctrl.instruction_valid
- in_op  in  2  dispatcher_div_inf.ctrl.div_control (div_op_t)
- in_rd  in  5  destination register
- in_rs1  in  XLEN  dividend
- in_rs2  in  XLEN  divisor
- div_done  out  1  one-cycle completion pulse to dispatcher
- wb_valid  out  1  write-back request
- wb_rd  out  5  write-back destination
- wb_data  out  XLEN  quotient or remainder

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, div_done=0, wb_valid=0, wb_rd=0, wb_data=0.
- FSM states: IDLE, CALC, DONE.
- IDLE, in_valid=1, flush=0 (cycle T):
  - Latch op, rd, sign flags, |rs1|, |rs2|.
  - Signed ops (DIV, REM) use two's-complement magnitude; unsigned ops take operands raw.
  - Divide-by-zero (rs2==0): goes to DONE with result DIV/DIVU=all ones, REM/REMU=rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): goes to DONE with result DIV=0x80000000, REM=0.
  - These fast paths apply only when ENABLE_FAST_SPECIAL=1. Otherwise the op iterates; the result must still match the values above.
  - All other cases: go to CALC, counter=XLEN-1, partial remainder R (XLEN+1 bits)=0, Q=|rs1|.
- CALC, per cycle:
  - {R,Q} shifted left 1; trial=R-{0,|rs2|}.
  - If trial is non-negative: R=trial and Q[0]=1, else Q[0]=0.
  - counter decrements; step at counter==0 goes to DONE.
  - CALC occupies exactly XLEN cycles.
- Sign fix (on entry to DONE):
  - Quotient negated when signed and sign(rs1)!=sign(rs2).
  - Remainder negated when signed and rs1 negative (remainder sign follows dividend).
  - wb_data=quotient for DIV/DIVU, remainder for REM/REMU.
- DONE (exactly 1 cycle):
  - div_done=1, wb_valid=1, wb_rd=latched rd, wb_data=result.
  - Next state IDLE.
  - wb_data/wb_rd hold until the next completion; wb_valid and div_done are 0 outside DONE.
- Latency from in_valid sampled at T:
  - Normal ops: DONE at T+1+XLEN (T+33).
  - Fast-special ops: DONE at T+1.
- Back-to-back: a new in_valid is accepted in the IDLE cycle after DONE; in_valid in DONE is ignored.
- Busy: in_valid in CALC/DONE is ignored. The dispatcher guarantees none arrives; an assertion flags any.
- flush:
  - Synchronous, highest priority after rst.
  - Any state goes to IDLE; no div_done/wb_valid is produced for the aborted op.
  - flush in DONE suppresses the pulse.
  - flush together with in_valid in IDLE: op not accepted.
- rd=x0: written back normally; the register file ignores it.
- No WB backpressure: the dispatcher stalls issue while DIV is busy, so the DIV beat owns the WB port.

Decomposition:
- Shared package (defines.svh):
  - div_op_t {DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU}, already used by the dispatcher.
  - div_wb_inf_t {wr_en, rd, wr_data}.
  - LATENCY_DIV_OP=XLEN+1 in config.svh.
- Natural sub-module: div_restoring_step, a combinational single-bit shift/subtract/select. It keeps the datapath testable in isolation and allows later unrolling to 2 bits/cycle.

Test Plan:
- DIV 100/7, rd=5, at T: div_done and wb_valid high only at T+33; wb_rd=5, wb_data=14. Same operands with REM give 2.
- Signed: DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/1 gives 0xFFFFFFFF; REMU 0xFFFFFFFF/0x10 gives 0xF.
- Divide-by-zero, DIV 5/0: done at T+1 with 0xFFFFFFFF; REM 5/0 gives 5; REMU 0x80000000/0 gives 0x80000000.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV gives 0x80000000 at T+1; REM gives 0.
- flush at T+10 of a CALC op: no div_done through T+40. A new DIVU 9/3 issued at T+12 completes at T+45 with 3. flush in the DONE cycle gives no pulse.
- rst asserted asynchronously mid-CALC (between edges): all outputs 0 immediately, state IDLE. After release, DIV 100/7 gives correct 14 at +33.

Source files
------------

// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_pkg
// Description : Shared types and constants for the serial DIV execution pipe.
//               div_op_t is the dispatcher's DIV control encoding.
//               div_state_t holds the divider FSM encoding.
//               div_wb_inf_t is the write-back bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam int DIV_XLEN       = 32;
    // Cycles from issue to the completion beat for an iterating op
    localparam int LATENCY_DIV_OP = DIV_XLEN + 1;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic                wr_en;
        logic [4:0]          rd;
        logic [DIV_XLEN-1:0] wr_data;
    } div_wb_inf_t;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_restoring_step.sv
`default_nettype none
// ============================================================================
// Module      : div_unit_restoring_step
// Description : One combinational radix-2 restoring-division step.
//               The step shifts {R,Q} left by one bit.
//               It then trial-subtracts the divisor and keeps the result
//               only when the difference is non-negative.
// Ports       : rem_i  - partial remainder in (always < divisor)
//               quo_i  - quotient/dividend shift register in
//               dvs_i  - divisor magnitude
//               rem_o  - partial remainder out
//               quo_o  - quotient shift register out, new bit in [0]
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    // The remainder is always below the divisor, so XLEN bits hold it.
    // After the shift it can need one extra bit, so the working width is
    // XLEN+1.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_trial;

    always_comb begin
        w_shift = {rem_i, quo_i[XLEN-1]};
        w_trial = w_shift - {1'b0, dvs_i};
        if (!w_trial[XLEN]) begin
            rem_o = w_trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = w_shift[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule : div_unit_restoring_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Serial radix-2 restoring divider for RV32M.
//               Supports DIV, DIVU, REM and REMU.
//               It produces one quotient bit per cycle.
//               Each op ends with one write-back beat and a div_done pulse.
// Ports       : clk, rst (async, active-high), flush (sync abort)
//               in_valid/in_op/in_rd/in_rs1/in_rs2 - issue bundle
//               div_done - completion pulse to the dispatcher
//               wb_valid/wb_rd/wb_data - write-back beat
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN                = 32,
    parameter bit ENABLE_FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  div_op_t         in_op,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            div_done,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    localparam int CW = $clog2(XLEN);

    div_state_t      state_q,   state_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [XLEN-1:0] rem_q,     rem_d;
    logic [XLEN-1:0] quo_q,     quo_d;
    logic [XLEN-1:0] dvs_q,     dvs_d;
    logic            is_rem_q,  is_rem_d;
    logic            negq_q,    negq_d;
    logic            negr_q,    negr_d;
    logic [4:0]      rd_q,      rd_d;
    logic [4:0]      wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            w_signed;
    logic            w_is_rem;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    div_unit_restoring_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (w_step_rem),
        .quo_o (w_step_quo)
    );

    always_comb begin
        w_signed = (in_op == DIV_OP_DIV) || (in_op == DIV_OP_REM);
        w_is_rem = (in_op == DIV_OP_REM) || (in_op == DIV_OP_REMU);
        w_div0   = (in_rs2 == '0);
        w_ovf    = w_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
        w_abs1   = (w_signed && in_rs1[XLEN-1]) ? -in_rs1 : in_rs1;
        w_abs2   = (w_signed && in_rs2[XLEN-1]) ? -in_rs2 : in_rs2;
        w_quo_fix = negq_q ? -w_step_quo : w_step_quo;
        w_rem_fix = negr_q ? -w_step_rem : w_step_rem;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        is_rem_d  = is_rem_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        rd_d      = rd_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        rd_d     = in_rd;
                        is_rem_d = w_is_rem;
                        // A zero divisor iterates to an all-ones magnitude.
                        // Negating that would break the required result, so
                        // the quotient sign fix is skipped.
                        negq_d   = w_signed && (in_rs1[XLEN-1] ^ in_rs2[XLEN-1]) && !w_div0;
                        negr_d   = w_signed && in_rs1[XLEN-1];
                        dvs_d    = w_abs2;
                        if (ENABLE_FAST_SPECIAL && w_div0) begin
                            wb_rd_d   = in_rd;
                            wb_data_d = w_is_rem ? in_rs1 : '1;
                            state_d   = S_DONE;
                        end else if (ENABLE_FAST_SPECIAL && w_ovf) begin
                            wb_rd_d   = in_rd;
                            wb_data_d = w_is_rem ? '0 : in_rs1;
                            state_d   = S_DONE;
                        end else begin
                            cnt_d   = CW'(XLEN - 1);
                            rem_d   = '0;
                            quo_d   = w_abs1;
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_d = w_step_rem;
                    quo_d = w_step_quo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        wb_rd_d   = rd_q;
                        wb_data_d = is_rem_q ? w_rem_fix : w_quo_fix;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            is_rem_q  <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            is_rem_q  <= is_rem_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    // A flush in the DONE cycle must kill the beat in that same cycle.
    assign div_done = (state_q == S_DONE) && !flush;
    assign wb_valid = (state_q == S_DONE) && !flush;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

    // The dispatcher stalls issue while the divider is busy.
    a_no_issue_when_busy : assert property (
        @(posedge clk) disable iff (rst)
        !(in_valid && !flush && (state_q != S_IDLE))
    );

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Directed self-checking bench for div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    div_op_t     in_op;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        div_done;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.XLEN(32), .ENABLE_FAST_SPECIAL(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .div_done (div_done),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue in the current cycle, then wait for the beat and check it.
    // After the beat, the task returns in the following IDLE cycle, so
    // consecutive calls are back-to-back.
    task automatic run_op(input string tag, input div_op_t op, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_lat, input logic [31:0] exp_data);
        int n;
        in_op = op; in_rd = rd; in_rs1 = a; in_rs2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!div_done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq({tag, "_lat"},  n, exp_lat);
        chk_eq({tag, "_wbv"},  {31'd0, wb_valid}, 32'd1);
        chk_eq({tag, "_rd"},   {27'd0, wb_rd}, {27'd0, rd});
        chk_eq({tag, "_data"}, wb_data, exp_data);
        @(posedge clk); #1;
        chk_eq({tag, "_pulse"}, {31'd0, div_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int first_done;
        int n_done;
        logic [31:0] cap_data;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = DIV_OP_DIV; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_done",  {31'd0, div_done}, 32'd0);
        chk_eq("rst_wbv",   {31'd0, wb_valid}, 32'd0);
        chk_eq("rst_wbrd",  {27'd0, wb_rd}, 32'd0);
        chk_eq("rst_wbdat", wb_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal iterating ops
        run_op("div_100_7",  DIV_OP_DIV,  5'd5, 32'd100, 32'd7, LATENCY_DIV_OP, 32'd14);
        run_op("rem_100_7",  DIV_OP_REM,  5'd6, 32'd100, 32'd7, LATENCY_DIV_OP, 32'd2);
        run_op("div_m7_2",   DIV_OP_DIV,  5'd7, 32'hFFFF_FFF9, 32'd2, LATENCY_DIV_OP, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   DIV_OP_REM,  5'd8, 32'hFFFF_FFF9, 32'd2, LATENCY_DIV_OP, 32'hFFFF_FFFF);
        run_op("divu_max_1", DIV_OP_DIVU, 5'd9, 32'hFFFF_FFFF, 32'd1, LATENCY_DIV_OP, 32'hFFFF_FFFF);
        run_op("remu_max_16", DIV_OP_REMU, 5'd10, 32'hFFFF_FFFF, 32'h10, LATENCY_DIV_OP, 32'hF);
        run_op("div_7_m2",   DIV_OP_DIV,  5'd0, 32'd7, 32'hFFFF_FFFE, LATENCY_DIV_OP, 32'hFFFF_FFFD);

        // Fast special cases
        run_op("div_5_0",    DIV_OP_DIV,  5'd11, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("rem_5_0",    DIV_OP_REM,  5'd12, 32'd5, 32'd0, 1, 32'd5);
        run_op("remu_min_0", DIV_OP_REMU, 5'd13, 32'h8000_0000, 32'd0, 1, 32'h8000_0000);
        run_op("div_ovf",    DIV_OP_DIV,  5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf",    DIV_OP_REM,  5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // Flush at T+10 of a CALC op, then a new DIVU 9/3 issued at T+12.
        in_op = DIV_OP_DIV; in_rd = 5'd3; in_rs1 = 32'd100; in_rs2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        first_done = 0; n_done = 0; cap_data = '0;
        for (int c = 1; c <= 50; c++) begin
            if (div_done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = c;
                    cap_data   = wb_data;
                end
            end
            flush = (c == 10);
            if (c == 12) begin
                in_op = DIV_OP_DIVU; in_rd = 5'd4; in_rs1 = 32'd9; in_rs2 = 32'd3; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        flush = 1'b0;
        chk_eq("flush_first_done", first_done, 45);
        chk_eq("flush_n_done",     n_done, 1);
        chk_eq("flush_new_data",   cap_data, 32'd3);

        // Flush in the DONE cycle suppresses the beat.
        in_op = DIV_OP_DIV; in_rd = 5'd1; in_rs1 = 32'd5; in_rs2 = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk_eq("flush_done_pulse", {31'd0, div_done}, 32'd0);
        chk_eq("flush_done_wbv",   {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk_eq("flush_done_after", {31'd0, div_done}, 32'd0);

        // Flush with in_valid in IDLE: the op is not accepted.
        in_op = DIV_OP_DIV; in_rd = 5'd2; in_rs1 = 32'd5; in_rs2 = 32'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (div_done) n_done++;
            @(posedge clk); #1;
        end
        chk_eq("flush_issue_ignored", n_done, 0);

        // Async reset mid-CALC.
        in_op = DIV_OP_DIV; in_rd = 5'd20; in_rs1 = 32'd1000; in_rs2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_eq("arst_done",  {31'd0, div_done}, 32'd0);
        chk_eq("arst_wbv",   {31'd0, wb_valid}, 32'd0);
        chk_eq("arst_wbrd",  {27'd0, wb_rd}, 32'd0);
        chk_eq("arst_wbdat", wb_data, 32'd0);
        chk_eq("arst_state", {30'd0, dut.state_q}, {30'd0, S_IDLE});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("div_after_rst", DIV_OP_DIV, 5'd5, 32'd100, 32'd7, LATENCY_DIV_OP, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
